// File: rtl/wb_uart.sv
// wb_uart: Wishbone classic responder wrapping an 8N1 UART (TX + RX).
//   Bus side : CYC, STB, WE, ADR[3:2], DAT_I, CTI_I (ignored) -> DAT_O, ACK, ERR, RTY (tied 0)
//   Serial   : rx (asynchronous input, synchronised here), tx (idle high)
//   Registers: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 DIVISOR (clocks per bit, minimum 4)
module wb_uart #(
  parameter int unsigned DEFAULT_DIV = 434,
  parameter int unsigned DIV_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CYC,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] ADR,
  input  logic [31:0] DAT_I,
  input  logic [2:0]  CTI_I,
  output logic [31:0] DAT_O,
  output logic        ACK,
  output logic        ERR,
  output logic        RTY,
  input  logic        rx,
  output logic        tx
);

  localparam int unsigned DW      = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned BCNT_W  = 3;
  localparam int unsigned MIN_DIV = 4;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_DIVISOR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_st_e;

  // Bus-side registers
  logic              ack_q, err_q;
  logic [DW-1:0]     dat_o_q;
  logic [DIV_W-1:0]  divisor_q;
  logic [BYTE_W-1:0] hold_q;
  logic              hold_full_q;
  logic [BYTE_W-1:0] rx_byte_q;
  logic              rx_valid_q, overrun_q, frame_err_q;

  // TX engine
  uart_st_e          tx_st_q, tx_st_d;
  logic [DIV_W-1:0]  tx_cnt_q, tx_div_q;
  logic [BCNT_W-1:0] tx_bit_cnt_q;
  logic [BYTE_W-1:0] tx_shift_q;
  logic              tx_q;
  logic              tx_c, tx_busy_c, tx_load_c, tx_bit_done_c;

  // RX engine
  uart_st_e          rx_st_q, rx_st_d;
  logic [DIV_W-1:0]  rx_cnt_q, rx_div_q, rx_limit_c;
  logic [BCNT_W-1:0] rx_bit_cnt_q;
  logic [BYTE_W-1:0] rx_shift_q;
  logic              rx_s1_q, rx_s2_q, rx_prev_q;
  logic              rx_fall_c, rx_tick_c, rx_arm_c, rx_done_c, rx_frame_bad_c;

  // Bus decode
  logic              req_c, wr_tx_c, tx_accept_c, wr_div_c, rd_rx_c, rd_st_c;
  logic [DW-1:0]     rd_data_c;
  logic [DIV_W-1:0]  div_eff_c;
  logic              unused_c;

  assign unused_c = ^{CTI_I, ADR[31:4], ADR[1:0], DAT_I[DW-1:DIV_W]};

  assign DAT_O = dat_o_q;
  assign ACK   = ack_q;
  assign ERR   = err_q;
  assign RTY   = 1'b0;
  assign tx    = tx_q;

  // A request is only taken when no response is showing, so every response is followed by an idle cycle
  assign req_c       = CYC & STB & ~ack_q & ~err_q;
  assign wr_tx_c     = req_c & WE & (ADR[3:2] == REG_TXDATA);
  assign tx_accept_c = wr_tx_c & ~hold_full_q;
  assign wr_div_c    = req_c & WE & (ADR[3:2] == REG_DIVISOR);
  assign rd_rx_c     = req_c & ~WE & (ADR[3:2] == REG_RXDATA);
  assign rd_st_c     = req_c & ~WE & (ADR[3:2] == REG_STATUS);

  assign div_eff_c = (divisor_q < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : divisor_q;

  // Read mux
  always_comb begin
    rd_data_c = '0;
    case (ADR[3:2])
      REG_RXDATA:  rd_data_c = DW'({rx_valid_q, rx_byte_q});
      REG_STATUS:  rd_data_c = DW'({frame_err_q, overrun_q, rx_valid_q, hold_full_q, tx_busy_c});
      REG_DIVISOR: rd_data_c = DW'(divisor_q);
      default:     rd_data_c = '0;
    endcase
  end

  // Registered single-beat response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_o_q <= '0;
    end else begin
      ack_q   <= req_c & ~(wr_tx_c & hold_full_q);
      err_q   <= wr_tx_c & hold_full_q;
      dat_o_q <= (req_c & ~WE) ? rd_data_c : '0;
    end
  end

  // Divisor and TX holding register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor_q   <= DIV_W'(DEFAULT_DIV);
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      if (wr_div_c) divisor_q <= DAT_I[DIV_W-1:0];
      if (tx_accept_c) begin
        hold_q      <= DAT_I[BYTE_W-1:0];
        hold_full_q <= 1'b1;
      end else if (tx_load_c) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  // RX buffer and status flags; a completing frame wins over a same-cycle read-clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (rx_done_c) begin
        rx_byte_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
      end else if (rd_rx_c) begin
        rx_valid_q <= 1'b0;
      end
      if (rx_done_c & rx_valid_q & ~rd_rx_c) overrun_q <= 1'b1;
      else if (rd_st_c)                      overrun_q <= 1'b0;
      if (rx_frame_bad_c)                    frame_err_q <= 1'b1;
      else if (rd_st_c)                      frame_err_q <= 1'b0;
    end
  end

  // ---------------- TX ----------------

  assign tx_bit_done_c = (tx_cnt_q == tx_div_q - DIV_W'(1));

  // TX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_st_q <= S_IDLE;
    else      tx_st_q <= tx_st_d;
  end

  // TX next state
  always_comb begin
    tx_st_d = tx_st_q;
    case (tx_st_q)
      S_IDLE:  if (hold_full_q) tx_st_d = S_START;
      S_START: if (tx_bit_done_c) tx_st_d = S_DATA;
      S_DATA:  if (tx_bit_done_c && tx_bit_cnt_q == BCNT_W'(7)) tx_st_d = S_STOP;
      S_STOP:  if (tx_bit_done_c) tx_st_d = hold_full_q ? S_START : S_IDLE;
      default: tx_st_d = S_IDLE;
    endcase
  end

  // TX outputs: line level, busy flag, and shifter load (IDLE, or end of STOP for back-to-back frames)
  always_comb begin
    tx_c      = 1'b1;
    tx_busy_c = 1'b0;
    tx_load_c = 1'b0;
    case (tx_st_q)
      S_IDLE:  tx_load_c = hold_full_q;
      S_START: begin
        tx_c      = 1'b0;
        tx_busy_c = 1'b1;
      end
      S_DATA: begin
        tx_c      = tx_shift_q[0];
        tx_busy_c = 1'b1;
      end
      S_STOP: begin
        tx_busy_c = 1'b1;
        tx_load_c = hold_full_q & tx_bit_done_c;
      end
      default: tx_c = 1'b1;
    endcase
  end

  // TX datapath; divisor is re-latched at every bit boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt_q     <= '0;
      tx_div_q     <= DIV_W'(DEFAULT_DIV);
      tx_bit_cnt_q <= '0;
      tx_shift_q   <= '0;
      tx_q         <= 1'b1;
    end else begin
      tx_q <= tx_c;
      if (tx_load_c) begin
        tx_shift_q   <= hold_q;
        tx_cnt_q     <= '0;
        tx_div_q     <= div_eff_c;
        tx_bit_cnt_q <= '0;
      end else if (tx_st_q != S_IDLE) begin
        if (tx_bit_done_c) begin
          tx_cnt_q <= '0;
          tx_div_q <= div_eff_c;
          if (tx_st_q == S_DATA) begin
            tx_shift_q   <= {1'b0, tx_shift_q[BYTE_W-1:1]};
            tx_bit_cnt_q <= tx_bit_cnt_q + BCNT_W'(1);
          end
        end else begin
          tx_cnt_q <= tx_cnt_q + DIV_W'(1);
        end
      end
    end
  end

  // ---------------- RX ----------------

  // Two-flop synchroniser plus previous value for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign rx_fall_c  = rx_prev_q & ~rx_s2_q;
  // START waits half a bit so later samples land mid-bit
  assign rx_limit_c = (rx_st_q == S_START) ? (rx_div_q >> 1) : rx_div_q;
  assign rx_tick_c  = (rx_cnt_q == rx_limit_c - DIV_W'(1));

  // RX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_st_q <= S_IDLE;
    else      rx_st_q <= rx_st_d;
  end

  // RX next state
  always_comb begin
    rx_st_d = rx_st_q;
    case (rx_st_q)
      S_IDLE:  if (rx_fall_c) rx_st_d = S_START;
      S_START: if (rx_tick_c) rx_st_d = rx_s2_q ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick_c && rx_bit_cnt_q == BCNT_W'(7)) rx_st_d = S_STOP;
      S_STOP:  if (rx_tick_c) rx_st_d = S_IDLE;
      default: rx_st_d = S_IDLE;
    endcase
  end

  // RX outputs: arm on falling edge, completion and framing check at the stop sample
  always_comb begin
    rx_arm_c       = 1'b0;
    rx_done_c      = 1'b0;
    rx_frame_bad_c = 1'b0;
    case (rx_st_q)
      S_IDLE: rx_arm_c = rx_fall_c;
      S_STOP: begin
        rx_done_c      = rx_tick_c;
        rx_frame_bad_c = rx_tick_c & ~rx_s2_q;
      end
      default: rx_arm_c = 1'b0;
    endcase
  end

  // RX datapath: LSB arrives first, so shift in from the top
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt_q     <= '0;
      rx_div_q     <= DIV_W'(DEFAULT_DIV);
      rx_bit_cnt_q <= '0;
      rx_shift_q   <= '0;
    end else if (rx_arm_c) begin
      rx_cnt_q     <= '0;
      rx_div_q     <= div_eff_c;
      rx_bit_cnt_q <= '0;
    end else if (rx_st_q != S_IDLE) begin
      if (rx_tick_c) begin
        rx_cnt_q <= '0;
        rx_div_q <= div_eff_c;
        if (rx_st_q == S_DATA) begin
          rx_shift_q   <= {rx_s2_q, rx_shift_q[BYTE_W-1:1]};
          rx_bit_cnt_q <= rx_bit_cnt_q + BCNT_W'(1);
        end
      end else begin
        rx_cnt_q <= rx_cnt_q + DIV_W'(1);
      end
    end
  end

endmodule
